mem_wrapper_pipe: RTL

//  Parametrised single-port data memory with valid/ready request and response channels.

---
 rtl/mem_wrapper_pipe_pkg.sv | 15 +
 rtl/mem_wrapper_ram.sv | 52 +++++
 rtl/mem_wrapper_pipe.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_wrapper_pipe_pkg.sv
// Shared defaults for the pipelined memory wrapper.
// Also holds the read-latency legality helper used at elaboration.
package mem_wrapper_pipe_pkg;

    localparam int MEM_DATA_W  = 16;
    localparam int MEM_ADDR_W  = 16;
    localparam int MEM_DEPTH   = 1024;
    localparam int MEM_RD_LAT  = 1;
    localparam int MEM_INIT_ID = 1;

    function automatic bit rd_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/mem_wrapper_ram.sv
// Sync single-port RAM, byte-enable writes, write-first registered read data.
// Latency: 1 cycle from an enabled edge to rd_dat.
// Backpressure: rd_en low freezes the output register and blocks writes.
module mem_wrapper_ram
    import mem_wrapper_pipe_pkg::*;
#(
    parameter  int DATA_W  = MEM_DATA_W,
    parameter  int DEPTH   = MEM_DEPTH,
    parameter  int INIT_ID = MEM_INIT_ID,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NB      = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [NB-1:0]     byte_en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_dat,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged;

    // Power-up image only; reset never touches the array.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = (INIT_ID != 0) ? DATA_W'(i) : '0;
        end
    end

    always_comb begin
        merged = mem[addr];
        for (int b = 0; b < NB; b++) begin
            if (wr_en && byte_en[b]) begin
                merged[b*8 +: 8] = wr_dat[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rd_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_en && byte_en[b]) begin
                    mem[addr][b*8 +: 8] <= wr_dat[b*8 +: 8];
                end
            end
            rd_dat <= merged;
        end
    end

endmodule

// File: rtl/mem_wrapper_pipe.sv
// Valid/ready data memory wrapper with OOB flagging and a sticky first-bad-address log.
// Latency: RD_LAT (1 or 2) cycles accept-to-response, throughput 1 per cycle.
// Backpressure: a held response freezes every stage; ReqReady = !RespValid || RespReady.
module mem_wrapper_pipe
    import mem_wrapper_pipe_pkg::*;
#(
    parameter int DATA_W  = MEM_DATA_W,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DEPTH   = MEM_DEPTH,
    parameter int RD_LAT  = MEM_RD_LAT,
    parameter int INIT_ID = MEM_INIT_ID
) (
    input  logic                  CLK,
    input  logic                  ResetN,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [ADDR_W-1:0]     Addr,
    input  logic [DATA_W-1:0]     DIn,
    input  logic [DATA_W/8-1:0]   ByteEn,
    output logic                  RespValid,
    input  logic                  RespReady,
    output logic [DATA_W-1:0]     DOut,
    output logic                  MemOOB,
    output logic                  OOBSticky,
    output logic [ADDR_W-1:0]     OOBAddr,
    input  logic                  OOBClear
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("mem_wrapper_pipe: RD_LAT must be 1 or 2");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("mem_wrapper_pipe: DATA_W must be a multiple of 8");
    end

    logic              adv;
    logic              acc;
    logic              in_range;
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] oob_q;
    logic [DATA_W-1:0] ram_dat;
    logic [DATA_W-1:0] out_dat;

    assign adv      = !vld_q[RD_LAT-1] || RespReady;
    assign acc      = ReqValid && adv;
    // Extra top bit so DEPTH == 2**ADDR_W still compares correctly.
    assign in_range = {1'b0, Addr} < (ADDR_W+1)'(DEPTH);
    assign ReqReady = adv;

    mem_wrapper_ram #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .INIT_ID (INIT_ID)
    ) u_ram (
        .CLK     (CLK),
        .rd_en   (adv),
        .wr_en   (acc && ReqWrite && in_range),
        .byte_en (ByteEn),
        .addr    (Addr[AW-1:0]),
        .wr_dat  (DIn),
        .rd_dat  (ram_dat)
    );

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            vld_q <= '0;
            oob_q <= '0;
        end else if (adv) begin
            vld_q[0] <= acc;
            oob_q[0] <= acc && !in_range;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                oob_q[i] <= oob_q[i-1];
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] dat_q;
        always_ff @(posedge CLK or negedge ResetN) begin
            if (!ResetN) begin
                dat_q <= '0;
            end else if (adv) begin
                dat_q <= ram_dat;
            end
        end
        assign out_dat = dat_q;
    end else begin : g_lat1
        assign out_dat = ram_dat;
    end

    assign RespValid = vld_q[RD_LAT-1];
    assign MemOOB    = oob_q[RD_LAT-1];
    // Masking keeps DOut at zero out of reset and for OOB responses.
    assign DOut      = (RespValid && !MemOOB) ? out_dat : '0;

    // A new OOB accept beats a simultaneous clear and reloads the address.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            OOBSticky <= 1'b0;
            OOBAddr   <= '0;
        end else if (acc && !in_range && (!OOBSticky || OOBClear)) begin
            OOBSticky <= 1'b1;
            OOBAddr   <= Addr;
        end else if (OOBClear) begin
            OOBSticky <= 1'b0;
            OOBAddr   <= '0;
        end
    end

endmodule
